// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo: first-word-fall-through trace buffer that stops capturing on trap
// and reports done once every captured word has been drained.
module trace_capture_fifo #(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   trace_valid,
    input  logic [35:0]            trace_data,
    input  logic                   trap,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [35:0]            out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [OVF_W-1:0]       ovf_count,
    output logic                   done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [35:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push_req, push, pop, drop;
    logic [AW:0] level_nx;
    assign out_valid = level != '0;
    assign out_data = mem[rd_ptr];
    assign done = state == DONE;
    always_comb begin
        pop = out_valid && out_ready;
        push_req = state == CAPTURE && trace_valid;
        // a pop in the same cycle frees the slot, so a full FIFO can still accept
        push = push_req && (level != FULL || pop);
        drop = push_req && !push;
        level_nx = level + (AW+1)'(push) - (AW+1)'(pop);
        state_nx = (state == CAPTURE && trap) ? DRAIN :
                   (state == DRAIN && level_nx == '0) ? DONE : state;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CAPTURE;
            level <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_count <= '0;
        end else begin
            state <= state_nx;
            level <= level_nx;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (drop && ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= trace_data;
    end
endmodule

// File: tb/tb_trace_capture_fifo.sv
// tb_trace_capture_fifo: random and directed stimulus against a queue-based reference
// model, with a negedge monitor scoring every output handshake.
module tb_trace_capture_fifo;
    localparam int DEPTH = 16;
    localparam int OVF_W = 3;
    localparam int OVF_MAX = 2**OVF_W - 1;
    logic clk = 0;
    logic resetn, trace_valid, trap, out_ready, out_valid, done;
    logic [35:0] trace_data, out_data;
    logic [4:0] level;
    logic [OVF_W-1:0] ovf_count;
    int n_chk = 0, n_fail = 0;
    logic [35:0] model_q[$], exp_q[$];
    int mst = 0, movf = 0, acc_cnt = 0;
    bit m_pop, stall_prev = 0;
    logic [35:0] prev_data;

    trace_capture_fifo #(.DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
        .clk(clk), .resetn(resetn), .trace_valid(trace_valid), .trace_data(trace_data),
        .trap(trap), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .level(level), .ovf_count(ovf_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: FIFO contents as a queue, state 0=capture 1=drain 2=done
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            model_q.delete();
            exp_q.delete();
            mst = 0;
            movf = 0;
        end else begin
            m_pop = model_q.size() != 0 && out_ready;
            if (mst == 0 && trace_valid) begin
                if (model_q.size() < DEPTH || m_pop) begin
                    model_q.push_back(trace_data);
                    exp_q.push_back(trace_data);
                    acc_cnt++;
                end else if (movf < OVF_MAX) movf++;
            end
            if (m_pop) void'(model_q.pop_front());
            if (mst == 0 && trap) mst = 1;
            else if (mst == 1 && model_q.size() == 0) mst = 2;
        end
    end

    always @(negedge resetn) stall_prev = 0;

    always @(negedge clk) begin
        if (resetn) begin
            chk("out_valid", out_valid, model_q.size() != 0);
            chk("level", level, model_q.size());
            chk("ovf_count", ovf_count, movf);
            chk("done", done, mst == 2);
            if (stall_prev && out_valid) chk("stall_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_empty: got 0x%0h expected no output", out_data);
                end else chk("out_data", out_data, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic cyc(input logic v, input logic [35:0] d, input logic t, input logic r);
        trace_valid = v;
        trace_data = d;
        trap = t;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #1 resetn = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf_count, 0);
        chk("rst_done", done, 0);
        #1 resetn = 1;
        trace_valid = 0;
        trap = 0;
        out_ready = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, cn;
        logic [35:0] w;
        resetn = 0;
        trace_valid = 0;
        trace_data = '0;
        trap = 0;
        out_ready = 0;
        #3;
        chk("init_out_valid", out_valid, 0);
        chk("init_level", level, 0);
        chk("init_ovf", ovf_count, 0);
        chk("init_done", done, 0);
        @(posedge clk);
        #1 resetn = 1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 36'(i), 0, 1);
            chk("basic_valid", out_valid, 1);
            chk("basic_level_le1", level <= 1, 1);
        end
        repeat (2) cyc(0, 0, 0, 1);
        chk("basic_empty", level, 0);
        for (int i = 0; i < 20; i++) cyc(1, 36'(i), 0, 0);
        chk("ovf_level", level, 16);
        chk("ovf_count4", ovf_count, 4);
        cyc(1, 36'hABC, 0, 1);
        chk("full_simul_level", level, 16);
        chk("full_simul_ovf", ovf_count, 4);
        repeat (17) cyc(0, 0, 0, 1);
        chk("full_drained", level, 0);
        for (int i = 0; i < 21; i++) cyc(1, 36'h200 + 36'(i), 0, 0);
        chk("ovf_saturate", ovf_count, OVF_MAX);
        repeat (17) cyc(0, 0, 0, 1);
        async_reset();
        for (int i = 0; i < 18; i++) cyc(1, 36'h300 + 36'(i), 0, 0);
        repeat (9) cyc(0, 0, 0, 1);
        chk("pre_rst_level", level, 7);
        chk("pre_rst_ovf", ovf_count, 2);
        async_reset();
        for (int i = 0; i < 3; i++) cyc(1, 36'h11 + 36'(i), 0, 0);
        chk("trap_pre_level", level, 3);
        cyc(1, 36'h5, 1, 0);
        chk("trap_word_pushed", level, 4);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 36'h100 + 36'(i), 0, 1);
            chk("trap_done", done, i >= 3);
        end
        chk("trap_no_ovf", ovf_count, 0);
        repeat (2) cyc(1, 36'h77, 1, 1);
        chk("done_terminal", done, 1);
        chk("done_level", level, 0);
        async_reset();
        acc0 = acc_cnt;
        cn = 0;
        while (acc_cnt - acc0 < 40 && cn < 2000) begin
            w = {4'($urandom_range(0, 15)), $urandom()};
            cyc(1'($urandom_range(0, 1)), w, 0, $urandom_range(0, 2) != 0);
            cn++;
        end
        chk("rand_words_accepted", acc_cnt - acc0 >= 40, 1);
        repeat (DEPTH + 2) cyc(0, 0, 0, 1);
        chk("rand_drained", level, 0);
        chk("rand_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
